// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared types, opcode constants and field positions for the SISC fetch path
package sisc_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 32;

  localparam int OPC_MSB = 31;
  localparam int MM_MSB  = 27;
  localparam int IMM_W   = 16;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_LOD  = 4'h1;
  localparam logic [3:0] OP_STR  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_BRA  = 4'hC;
  localparam logic [3:0] OP_BRC  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

endpackage

// File: rtl/sisc_next_pc.sv
// rtl/sisc_next_pc.sv - next program counter: increment, absolute or relative branch
module sisc_next_pc #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] imm,
  input  logic            pc_sel,
  input  logic            br_sel,
  output logic [PC_W-1:0] next_pc
);

  // Plain PC_W-bit adds: the carry out is dropped so the PC wraps naturally.
  always_comb begin
    next_pc = pc + PC_W'(1);
    if (pc_sel) begin
      if (br_sel) next_pc = imm;
      else        next_pc = pc + imm;
    end
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// rtl/sisc_fetch_unit.sv - PC/IR fetch stage with req/ack memory handshake (optional FETCH_TIMEOUT_EN)
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int PC_W           = PC_W_DEF,
  parameter int INSTR_W        = INSTR_W_DEF,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  output logic [PC_W-1:0]    im_addr,
  output logic               im_req,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [PC_W-1:0]    pc_out,
  output logic               fetch_busy,
  output logic               fetch_err
);

  fetch_state_t      state, state_nxt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   fetch_addr;
  logic [PC_W-1:0]   imm_ext;
  logic [PC_W-1:0]   next_pc;
  logic              timeout_hit;

  always_comb begin
    imm_ext = '0;
    imm_ext = PC_W'(ir[IMM_W-1:0]);
  end

  sisc_next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc      (pc),
    .imm     (imm_ext),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .next_pc (next_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Counter value equals REQ cycles already spent without ack, so the abort
  // lands on the edge that closes the TIMEOUT_CYCLES-th REQ cycle.
  assign timeout_hit = (state == FETCH_REQ) && !im_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == FETCH_IDLE && ir_load) wait_cnt <= '0;
      else if (state == FETCH_REQ && !im_ack && !timeout_hit) wait_cnt <= wait_cnt + CNT_W'(1);
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_f) state <= FETCH_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE: if (ir_load) state_nxt = FETCH_REQ;
      FETCH_REQ:  if (im_ack || timeout_hit) state_nxt = FETCH_IDLE;
      default:    state_nxt = FETCH_IDLE;
    endcase
  end

  always_comb begin
    im_req     = 1'b0;
    fetch_busy = 1'b0;
    if (state == FETCH_REQ) begin
      im_req     = 1'b1;
      fetch_busy = 1'b1;
    end
  end

  // fetch_addr samples pc before any same-edge pc_write takes effect.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      pc         <= '0;
      ir         <= '0;
      fetch_addr <= '0;
    end else begin
      if (pc_rst)        pc <= '0;
      else if (pc_write) pc <= next_pc;

      if (state == FETCH_IDLE && ir_load) fetch_addr <= pc;

      if (state == FETCH_REQ && im_ack) ir <= im_rdata;
      else if (timeout_hit)             ir <= {OP_NOOP, {(INSTR_W-4){1'b0}}};
    end
  end

  assign im_addr = fetch_addr;
  assign pc_out  = pc;
  assign opcode  = ir[OPC_MSB -: 4];
  assign mm      = ir[MM_MSB -: 4];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// tb/tb_sisc_fetch_unit.sv - self-checking bench for sisc_fetch_unit
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, im_ack;
  logic [31:0] im_rdata, ir;
  logic [15:0] im_addr, pc_out;
  logic        im_req, fetch_busy, fetch_err;
  logic [3:0]  opcode, mm;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_pc;
  logic [31:0] m_ir;

  always #5 clk = ~clk;

  sisc_fetch_unit dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load), .im_addr(im_addr),
    .im_req(im_req), .im_ack(im_ack), .im_rdata(im_rdata), .ir(ir),
    .opcode(opcode), .mm(mm), .pc_out(pc_out), .fetch_busy(fetch_busy),
    .fetch_err(fetch_err)
  );

  typedef struct {
    logic [31:0] ir_val;
    logic [15:0] start_pc;
    logic        sel;
    logic        br;
    logic [15:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_next(input int unsigned pc, input int unsigned irv,
                                           input bit sel, input bit br);
    int unsigned imm;
    imm = irv % 65536;
    if (!sel) return 16'((pc + 1) % 65536);
    if (br)   return 16'(imm);
    return 16'((pc + imm) % 65536);
  endfunction

  task automatic do_reset();
    rst_f = 1'b0; pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0;
    ir_load = 0; im_ack = 0; im_rdata = '0;
    tick(); tick();
    rst_f = 1'b1;
    m_pc = '0; m_ir = '0;
  endtask

  task automatic fetch(input logic [31:0] data, input int waits,
                       input logic pw, input logic ps, input logic bs);
    logic [15:0] exp_addr;
    exp_addr = m_pc;
    ir_load = 1; pc_write = pw; pc_sel = ps; br_sel = bs; im_ack = 0;
    tick();
    if (pw) m_pc = ref_next(m_pc, m_ir, ps, bs);
    ir_load = 0; pc_write = 0;
    for (int k = 0; k < waits; k++) begin
      check("wait_busy", fetch_busy, 1);
      check("wait_addr", im_addr, exp_addr);
      ir_load = 1'($urandom_range(0, 1));
      tick();
    end
    ir_load = 0;
    check("req_high", im_req, 1);
    check("req_addr", im_addr, exp_addr);
    check("req_pc", pc_out, m_pc);
    im_ack = 1; im_rdata = data;
    tick();
    im_ack = 0; im_rdata = $urandom;
    m_ir = data;
    check("fetch_ir", ir, m_ir);
    check("fetch_done", fetch_busy, 0);
    check("addr_hold", im_addr, exp_addr);
  endtask

  task automatic pc_op(input logic rst, input logic pw, input logic ps, input logic bs);
    pc_rst = rst; pc_write = pw; pc_sel = ps; br_sel = bs;
    tick();
    pc_rst = 0; pc_write = 0;
    if (rst)     m_pc = '0;
    else if (pw) m_pc = ref_next(m_pc, m_ir, ps, bs);
    check("pc_op", pc_out, m_pc);
  endtask

  task automatic set_pc(input logic [15:0] v);
    fetch({16'h0, v}, 0, 0, 0, 0);
    pc_op(0, 1, 1, 1);
  endtask

  initial begin
    int busy_cycles;
    vecs[0] = '{32'h4000_0020, 16'h0005, 1'b1, 1'b1, 16'h0020};
    vecs[1] = '{32'h4000_0020, 16'h0005, 1'b1, 1'b0, 16'h0025};
    vecs[2] = '{32'h4000_0020, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{32'h0000_FFFF, 16'h0002, 1'b1, 1'b0, 16'h0001};
    vecs[4] = '{32'h7ABC_FFF0, 16'h0100, 1'b1, 1'b1, 16'hFFF0};
    vecs[5] = '{32'h1234_0001, 16'h1234, 1'b0, 1'b1, 16'h1235};

    do_reset();
    check("rst_pc", pc_out, 0);
    check("rst_ir", ir, 0);
    check("rst_req", im_req, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_err", fetch_err, 0);
    check("rst_addr", im_addr, 0);

    // zero-wait fetch, ack held high throughout
    im_ack = 1; im_rdata = 32'h1800_0005; ir_load = 1;
    tick();
    ir_load = 0;
    check("zw_req", im_req, 1);
    check("zw_addr", im_addr, 0);
    check("zw_ir_early", ir, 0);
    tick();
    im_ack = 0;
    check("zw_ir", ir, 32'h1800_0005);
    check("zw_opcode", opcode, 4'h1);
    check("zw_mm", mm, 4'h8);
    check("zw_idle", im_req, 0);
    m_ir = 32'h1800_0005;

    // next-PC table
    for (int i = 0; i < 6; i++) begin
      set_pc(vecs[i].start_pc);
      fetch(vecs[i].ir_val, 0, 0, 0, 0);
      pc_write = 1; pc_sel = vecs[i].sel; br_sel = vecs[i].br;
      tick();
      pc_write = 0;
      check($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
      m_pc = vecs[i].exp_pc;
    end

    // fetch at pc=3 with same-edge increment, ack on the 4th REQ cycle
    set_pc(16'h0003);
    ir_load = 1; pc_write = 1; pc_sel = 0;
    tick();
    ir_load = 0; pc_write = 0;
    busy_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      check("d4_addr", im_addr, 16'h0003);
      check("d4_pc", pc_out, 16'h0004);
      if (fetch_busy) busy_cycles++;
      ir_load = (k == 1);
      im_ack = (k == 3); im_rdata = 32'hA5A5_0003;
      tick();
    end
    im_ack = 0; ir_load = 0;
    check("d4_busy_cycles", busy_cycles, 4);
    check("d4_done", fetch_busy, 0);
    check("d4_ir", ir, 32'hA5A5_0003);
    tick();
    check("d4_no_restart", im_req, 0);
    check("d4_addr_hold", im_addr, 16'h0003);
    m_pc = 16'h0004; m_ir = 32'hA5A5_0003;

    // ack in IDLE is ignored
    im_ack = 1; im_rdata = 32'hDEAD_BEEF;
    tick();
    im_ack = 0;
    check("idle_ack_ir", ir, 32'hA5A5_0003);
    check("idle_ack_busy", fetch_busy, 0);

    pc_op(1, 1, 0, 0);
    check("pcrst_wins", pc_out, 0);

    // reset mid-fetch
    ir_load = 1;
    tick();
    ir_load = 0;
    check("mid_req", im_req, 1);
    rst_f = 0;
    tick();
    rst_f = 1;
    check("mid_req_drop", im_req, 0);
    check("mid_ir", ir, 0);
    im_ack = 1; im_rdata = 32'h5555_AAAA;
    tick();
    im_ack = 0;
    check("mid_late_ack", ir, 0);
    check("mid_busy", fetch_busy, 0);
    m_pc = '0; m_ir = '0;

    // randomized traffic against the reference model
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0)
        fetch($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        pc_op($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rnd_opcode", opcode, m_ir[31:28]);
      check("rnd_mm", mm, m_ir[27:24]);
    end

`ifdef FETCH_TIMEOUT_EN
    do_reset();
    fetch(32'h3300_1111, 0, 0, 0, 0);
    ir_load = 1;
    tick();
    ir_load = 0;
    for (int k = 0; k < 14; k++) tick();
    check("to_busy_14", fetch_busy, 1);
    check("to_err_pre", fetch_err, 0);
    tick();
    check("to_idle", fetch_busy, 0);
    check("to_ir_noop", ir, 0);
    check("to_err", fetch_err, 1);
    tick();
    check("to_err_sticky", fetch_err, 1);
    do_reset();
    ir_load = 1;
    tick();
    ir_load = 0;
    for (int k = 0; k < 14; k++) tick();
    im_ack = 1; im_rdata = 32'h9900_0042;
    tick();
    im_ack = 0;
    check("to_ack_ir", ir, 32'h9900_0042);
    check("to_ack_err", fetch_err, 0);
    check("to_ack_idle", fetch_busy, 0);
`else
    ir_load = 1;
    tick();
    ir_load = 0;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (fetch_busy) busy_cycles++;
      tick();
    end
    check("nt_wait_forever", busy_cycles, 20);
    check("nt_err", fetch_err, 0);
    im_ack = 1; im_rdata = 32'h2200_0007;
    tick();
    im_ack = 0;
    check("nt_ir", ir, 32'h2200_0007);
    check("nt_idle", fetch_busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the SISC control FSM. Holds the program counter and instruction register, and computes next-PC (increment, absolute branch, relative branch). Runs a req/ack handshake to instruction memory so fetches may take wait states. Presents opcode/mm fields to the controller and reports stall via fetch_busy.

Parameters:
PC_W, 16, program counter / instruction address width
INSTR_W, 32, instruction width
TIMEOUT_CYCLES, 15, max REQ cycles before abort (only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst_f  in  1  reset, synchronous, active-low
pc_rst  in  1  from ctrl: clear PC to 0
pc_write  in  1  from ctrl: update PC this edge
pc_sel  in  1  0 = PC+1, 1 = branch target
br_sel  in  1  1 = absolute target ir[15:0], 0 = relative PC + ir[15:0]
ir_load  in  1  from ctrl: start fetch at current PC
im_addr  out  PC_W  instruction memory address
im_req  out  1  fetch request
im_ack  in  1  memory: im_rdata valid this cycle
im_rdata  in  INSTR_W  fetched instruction
ir  out  INSTR_W  instruction register
opcode  out  4  ir[31:28]
mm  out  4  ir[27:24]
pc_out  out  PC_W  current PC
fetch_busy  out  1  high while a fetch is outstanding
fetch_err  out  1  sticky timeout flag (0 when FETCH_TIMEOUT_EN undefined)

Behaviour:
- Reset (rst_f low at clk edge): pc=0, ir=0, fetch_addr=0, state IDLE, im_req=0, fetch_busy=0, fetch_err=0, wait counter=0. rst_f beats every other input.
- PC update, priority: pc_rst -> 0; else pc_write -> next_pc; else hold.
- next_pc: pc_sel=0 -> pc+1; pc_sel=1 & br_sel=1 -> ir[15:0]; pc_sel=1 & br_sel=0 -> pc + ir[15:0]. All arithmetic is modulo 2^PC_W: 16'hFFFF+1 = 0, no carry out.
- FSM states IDLE, REQ.
  - IDLE: ir_load=1 -> capture fetch_addr<=pc (value before any same-edge pc_write), go REQ. Otherwise stay.
  - REQ: im_req=1, im_addr=fetch_addr, fetch_busy=1. im_ack=1 -> ir<=im_rdata, go IDLE.
- im_req and fetch_busy are registered: high from the edge after ir_load until the edge that samples im_ack.
- Zero-wait memory (ack in first REQ cycle): ir valid 2 edges after the ir_load edge.
- ir_load while in REQ: ignored, no restart, fetch_addr unchanged.
- im_ack while in IDLE: ignored; ir unchanged.
- Same-edge pc_write and ir_load: the fetch uses the old PC and the PC advances. This is the normal fetch-cycle case.
- im_addr holds fetch_addr in IDLE.
- opcode and mm are combinational slices of ir.
- Reset mid-fetch: REQ is abandoned, im_req drops at that edge, and a later ack is ignored.

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on REQ entry and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack: ir <= 0 (NOOP), fetch_err <= 1 (sticky until reset), go IDLE.
  - An ack in the same cycle as the timeout wins: the data is loaded and no error is flagged.
- Undefined: REQ waits indefinitely, no counter, and fetch_err is tied to 0.

Decomposition:
- Package sisc_pkg:
  - fetch state enum (IDLE, REQ)
  - opcode constants (NOOP=0 … HLT=15)
  - field positions: OPC_MSB=31, MM_MSB=27, IMM_W=16
  - PC_W and INSTR_W defaults
- Sub-module sisc_next_pc: combinational next-PC mux/adder (pc, imm, pc_sel, br_sel -> next_pc). Checked separately for wrap cases.

Test Plan:
- Reset then ir_load with im_ack tied 1 and im_rdata=32'h1800_0005 -> im_addr=0, ir=32'h1800_0005 two edges later, opcode=1, mm=8.
- ir_load+pc_write(pc_sel=0) at pc=3 with ack delayed 4 cycles -> im_addr=3 for 4 cycles, fetch_busy high for 4 cycles, pc_out=4, a second ir_load mid-fetch is ignored.
- ir=32'h4000_0020, pc=5: pc_write, pc_sel=1, br_sel=1 -> pc=16'h0020. Same with br_sel=0 -> pc=16'h0025. pc=16'hFFFF, pc_sel=0 -> pc=0.
- pc_rst and pc_write in the same cycle -> pc=0. rst_f low during REQ -> im_req=0 next edge, and a following ack leaves ir=0.
- FETCH_TIMEOUT_EN defined, no ack -> after 15 REQ cycles ir=0, fetch_err=1, state IDLE. Ack on the 15th cycle -> data loaded, fetch_err=0.
